// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle: column sense in, row drive and decoded key out.
// slave = scanner side, master = board/UI side driving key_col.
interface keypad_scanner_if;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_value;

    modport master (
        output key_col,
        input  key_row,
        input  key_value
    );

    modport slave (
        input  key_col,
        output key_row,
        output key_value
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner. Drives rows one-hot, decodes a column press,
// publishes the key code on key_value after release.
// Ports: clk, rst (sync, active-high), pins (key_col in, key_row/key_value out).
module keypad_scanner #(
    parameter int ROW_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.slave  pins
);

    localparam int CNT_W = $clog2(ROW_CYCLES);

    typedef enum logic [1:0] {
        SCAN = 2'b00,
        HOLD = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       row_idx;
    logic [CNT_W-1:0] dwell;
    logic [3:0]       scanned_key;
    logic [3:0]       key_value;
    logic             pressed;

    // Codes: rows 0..2 give row*3+col+1; bottom row is * / 0 / #.
    function automatic logic [3:0] key_code(input logic [1:0] row,
                                            input logic [2:0] col);
        logic [1:0] c;
        if (col[2])
            c = 2'd0;
        else if (col[1])
            c = 2'd1;
        else
            c = 2'd2;
        if (row == 2'd3) begin
            case (c)
                2'd0:    key_code = 4'd10;
                2'd1:    key_code = 4'd0;
                default: key_code = 4'd11;
            endcase
        end else begin
            key_code = ({2'b00, row} * 4'd3) + {2'b00, c} + 4'd1;
        end
    endfunction

    assign pressed        = |pins.key_col;
    assign pins.key_row   = 4'b1000 >> row_idx;
    assign pins.key_value = key_value;

    always_ff @(posedge clk) begin
        if (rst)
            state <= SCAN;
        else
            state <= state_next;
    end

    // Encoding 2'b11 is unreachable; the default arm pulls it back to SCAN.
    always_comb begin
        state_next = SCAN;
        case (state)
            SCAN:    state_next = pressed ? HOLD : SCAN;
            HOLD:    state_next = pressed ? HOLD : DONE;
            DONE:    state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx     <= 2'd0;
            dwell       <= '0;
            scanned_key <= 4'hF;
            key_value   <= 4'hF;
        end else begin
            case (state)
                SCAN: begin
                    // A press freezes row and dwell so HOLD stays on that row.
                    if (pressed) begin
                        scanned_key <= key_code(row_idx, pins.key_col);
                    end else if (dwell == CNT_W'(ROW_CYCLES - 1)) begin
                        dwell   <= '0;
                        row_idx <= row_idx + 2'd1;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DONE: begin
                    key_value <= scanned_key;
                    dwell     <= '0;
                    row_idx   <= row_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: reset, row cycling, table of key
// presses, long hold and reset during HOLD.
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] kv_model;

    keypad_scanner_if pins ();

    keypad_scanner #(.ROW_CYCLES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (pins)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] row;
        logic [2:0] col;
        int         hold;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_row(input logic [3:0] row);
        int n;
        n = 0;
        while (pins.key_row !== row && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (pins.key_row !== row) begin
            checks++;
            errors++;
            $display("FAIL wait_row: got %0h expected %0h", pins.key_row, row);
        end
    endtask

    task automatic press(input logic [3:0] row, input logic [2:0] col,
                         input int hold, input logic [3:0] exp);
        logic frozen;
        frozen = 1'b1;
        wait_row(row);
        pins.key_col = col;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (pins.key_row !== row || pins.key_value !== kv_model)
                frozen = 1'b0;
        end
        chk("hold_state", 32'(dut.state), 32'd1);
        chk("scanned_key", 32'(dut.scanned_key), 32'(exp));
        chk("hold_frozen", 32'(frozen), 32'd1);
        pins.key_col = 3'b000;
        @(negedge clk);
        chk("done_state", 32'(dut.state), 32'd2);
        chk("kv_before", 32'(pins.key_value), 32'(kv_model));
        @(negedge clk);
        kv_model = exp;
        chk("key_value", 32'(pins.key_value), 32'(exp));
        chk("scan_state", 32'(dut.state), 32'd0);
        chk("next_row", 32'(pins.key_row), 32'({row[0], row[3:1]}));
    endtask

    initial begin
        vecs[0] = '{4'b0100, 3'b010, 2, 4'd5};
        vecs[1] = '{4'b0001, 3'b010, 2, 4'd0};
        vecs[2] = '{4'b0001, 3'b100, 2, 4'd10};
        vecs[3] = '{4'b0001, 3'b001, 2, 4'd11};
        vecs[4] = '{4'b1000, 3'b001, 20, 4'd3};
        vecs[5] = '{4'b0010, 3'b110, 2, 4'd7};
        vecs[6] = '{4'b1000, 3'b100, 1, 4'd1};
        vecs[7] = '{4'b0100, 3'b011, 3, 4'd5};
        vecs[8] = '{4'b0010, 3'b001, 2, 4'd9};
        vecs[9] = '{4'b0010, 3'b001, 2, 4'd9};

        kv_model     = 4'hF;
        rst          = 1'b1;
        pins.key_col = 3'b000;
        repeat (5) @(negedge clk);
        chk("rst_row", 32'(pins.key_row), 32'h8);
        chk("rst_state", 32'(dut.state), 32'd0);
        chk("rst_kv", 32'(pins.key_value), 32'hF);
        chk("rst_scanned", 32'(dut.scanned_key), 32'hF);
        rst = 1'b0;

        // Row advances after every 4 idle edges.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("cycle_row", 32'(pins.key_row),
                32'(4'b1000 >> (((i + 1) / 4) % 4)));
        end

        foreach (vecs[i])
            press(vecs[i].row, vecs[i].col, vecs[i].hold, vecs[i].exp);

        // Reset while a key is pending in HOLD.
        wait_row(4'b0010);
        pins.key_col = 3'b100;
        @(negedge clk);
        chk("pre_rst_hold", 32'(dut.state), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("hold_rst_state", 32'(dut.state), 32'd0);
        chk("hold_rst_kv", 32'(pins.key_value), 32'hF);
        chk("hold_rst_row", 32'(pins.key_row), 32'h8);
        chk("hold_rst_scanned", 32'(dut.scanned_key), 32'hF);
        rst          = 1'b0;
        pins.key_col = 3'b000;
        kv_model     = 4'hF;
        repeat (3) @(negedge clk);
        chk("post_rst_kv", 32'(pins.key_value), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
